// File: rtl/serdes_pkg.sv
// Shared definitions for the serial link: default word width, minimum legal burst
// length and the receive FSM state encoding.
package serdes_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int MIN_SER_LEN    = 3;

  typedef enum logic [1:0] {
    IDLE_S,
    RECV_S
  } deser_state_t;

endpackage

// File: rtl/deserializer_if.sv
// Link-side bundle of the deserializer: serial input qualified by a valid bit,
// parallel word output with its bit count, status pulses.
interface deserializer_if
  import serdes_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);
  localparam int MOD_W = $clog2(DATA_W);

  logic              ser_data_i;
  logic              ser_data_val_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_data_mod_o;
  logic              deser_data_val_o;
  logic              busy_o;
  logic              len_err_o;

  modport slave (
    input  ser_data_i, ser_data_val_i,
    output deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o, len_err_o
  );

  modport master (
    output ser_data_i, ser_data_val_i,
    input  deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o, len_err_o
  );

endinterface

// File: rtl/deserializer.sv
// Reassembles an MSB-first serial burst into a left-aligned parallel word plus bit count.
// Define DESERIALIZER_MIN_LEN_CHECK_EN to drop 1- and 2-bit bursts and flag them on len_err_o.
module deserializer
  import serdes_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic           clk_i,
  input  logic           arst_ni,
  deserializer_if.slave  bus
);

  localparam int MOD_W = $clog2(DATA_W);
  localparam int CNT_W = MOD_W + 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [MOD_W-1:0] TOP_IDX  = MOD_W'(DATA_W - 1);

  deser_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;

  logic              emit;
  logic [DATA_W-1:0] emit_data;
  logic [MOD_W-1:0]  emit_mod;

  logic [DATA_W-1:0] data_q, data_d;
  logic [MOD_W-1:0]  mod_q, mod_d;
  logic              val_q;

`ifdef DESERIALIZER_MIN_LEN_CHECK_EN
  logic drop;
  logic err_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    emit      = 1'b0;
    emit_data = shift_q;
    emit_mod  = cnt_q[MOD_W-1:0];
`ifdef DESERIALIZER_MIN_LEN_CHECK_EN
    drop      = 1'b0;
`endif
    case (state_q)
      IDLE_S: begin
        if (bus.ser_data_val_i) begin
          shift_d             = '0;
          shift_d[DATA_W-1]   = bus.ser_data_i;
          cnt_d               = CNT_W'(1);
          state_d             = RECV_S;
        end
      end
      RECV_S: begin
        if (bus.ser_data_val_i) begin
          shift_d[TOP_IDX - cnt_q[MOD_W-1:0]] = bus.ser_data_i;
          if (cnt_q == LAST_CNT) begin
            // Full word: count DATA_W wraps to 0 on the mod output.
            emit      = 1'b1;
            emit_data = shift_d;
            emit_mod  = '0;
            cnt_d     = '0;
            state_d   = IDLE_S;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          emit    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE_S;
`ifdef DESERIALIZER_MIN_LEN_CHECK_EN
          if (cnt_q < CNT_W'(MIN_SER_LEN)) begin
            emit = 1'b0;
            drop = 1'b1;
          end
`endif
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE_S;
      end
    endcase
  end

  // Data and count hold their last emitted value between pulses.
  always_comb begin
    data_d = data_q;
    mod_d  = mod_q;
    if (emit) begin
      data_d = emit_data;
      mod_d  = emit_mod;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE_S;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= emit;
    end
  end

`ifdef DESERIALIZER_MIN_LEN_CHECK_EN
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= drop;
    end
  end

  assign bus.len_err_o = err_q;
`else
  assign bus.len_err_o = 1'b0;
`endif

  assign bus.deser_data_o     = data_q;
  assign bus.deser_data_mod_o = mod_q;
  assign bus.deser_data_val_o = val_q;
  assign bus.busy_o           = (state_q == RECV_S);

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: the driver plays the serializer and queues the
// expected word/count/pulse cycle; a negedge monitor pops and compares on each output pulse.
module tb_deserializer;
  import serdes_pkg::*;

  localparam int DW = 16;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mod;
    bit          err;
    int          due;
  } exp_t;

  logic clk;
  logic arst_n;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  deserializer_if #(.DATA_W(DW)) bus ();

  deserializer #(.DATA_W(DW)) dut (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit short_dropped(input int n);
`ifdef DESERIALIZER_MIN_LEN_CHECK_EN
    return n < MIN_SER_LEN;
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_exp(input logic [15:0] w, input int n, input int due);
    exp_t        e;
    logic [15:0] ones;
    ones   = 16'hFFFF;
    e.data = w & ~(ones >> n);
    e.mod  = 4'(n);
    e.err  = short_dropped(n);
    e.due  = due;
    exp_q.push_back(e);
  endtask

  // Drive n bits of w MSB-first; close with one idle cycle unless n==DW and no close requested.
  task automatic send_burst(input logic [15:0] w, input int n, input bit close);
    for (int i = 0; i < n; i++) begin
      bus.ser_data_i     = w[15-i];
      bus.ser_data_val_i = 1'b1;
      if (i == DW - 1) push_exp(w, n, cyc + 1);
      @(posedge clk); #1;
      if (i == 0) check("busy_after_first", 32'(bus.busy_o), 32'(n != 1 || DW == 1 ? 1 : 1));
    end
    if (n < DW || close) begin
      bus.ser_data_i     = 1'($urandom_range(1, 0));
      bus.ser_data_val_i = 1'b0;
      if (n < DW) push_exp(w, n, cyc + 1);
      @(posedge clk); #1;
      check("busy_after_close", 32'(bus.busy_o), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    bus.ser_data_val_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.ser_data_i = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (arst_n && (bus.deser_data_val_o || bus.len_err_o)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({bus.deser_data_val_o, bus.len_err_o}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("val_o", 32'(bus.deser_data_val_o), 32'(!e.err));
        check("len_err_o", 32'(bus.len_err_o), 32'(e.err));
        if (!e.err) begin
          check("data_o", 32'(bus.deser_data_o), 32'(e.data));
          check("mod_o", 32'(bus.deser_data_mod_o), 32'(e.mod));
        end
        check("pulse_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    int n;
    logic [15:0] w;
    arst_n             = 1'b0;
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(bus.deser_data_o), 32'd0);
    check("rst_mod", 32'(bus.deser_data_mod_o), 32'd0);
    check("rst_val", 32'(bus.deser_data_val_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_err", 32'(bus.len_err_o), 32'd0);
    arst_n = 1'b1;
    idle(2);

    // Full word, continuous valid.
    send_burst(16'hA5C3, 16, 1'b0);
    idle(3);
    // Short burst 1,0,1,1,0.
    send_burst(16'hB000, 5, 1'b1);
    idle(3);
    // Back-to-back full words.
    send_burst(16'hFFFF, 16, 1'b0);
    send_burst(16'h0001, 16, 1'b0);
    idle(3);
    check("hold_data", 32'(bus.deser_data_o), 32'h0001);
    // Two-bit burst: emitted or flagged depending on build.
    send_burst(16'hC000, 2, 1'b1);
    idle(3);
    send_burst(16'h8000, 1, 1'b1);
    idle(3);

    // Reset mid-burst discards the partial word.
    for (int i = 0; i < 7; i++) begin
      bus.ser_data_i     = 1'b1;
      bus.ser_data_val_i = 1'b1;
      @(posedge clk); #1;
    end
    check("busy_mid_burst", 32'(bus.busy_o), 32'd1);
    arst_n             = 1'b0;
    bus.ser_data_val_i = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy_o), 32'd0);
    check("arst_data", 32'(bus.deser_data_o), 32'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    idle(2);
    send_burst(16'hE000, 3, 1'b1);
    idle(3);

    // Random bursts from the serializer model.
    for (int k = 0; k < 24; k++) begin
`ifdef DESERIALIZER_MIN_LEN_CHECK_EN
      n = $urandom_range(DW, MIN_SER_LEN);
`else
      n = $urandom_range(DW, 1);
`endif
      w = 16'($urandom);
      send_burst(w, n, 1'($urandom_range(1, 0)));
      if ($urandom_range(1, 0) == 1) idle($urandom_range(2, 1));
    end
    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
